// File: rtl/fma16_issue.sv
// Issue front end for the combinational fma16 datapath: accepts decoded FP16
// requests, holds operands for a settle window, and returns registered responses.
module fma16_issue #(
    parameter int EXEC_CYCLES = 1,
    parameter int TAG_W       = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [15:0]      req_x,
    input  logic [15:0]      req_y,
    input  logic [15:0]      req_z,
    input  logic [1:0]       req_rm,
    input  logic [TAG_W-1:0] req_tag,
    output logic [15:0]      fma_x,
    output logic [15:0]      fma_y,
    output logic [15:0]      fma_z,
    output logic             fma_mul,
    output logic             fma_add,
    output logic             fma_negr,
    output logic             fma_negz,
    output logic [1:0]       fma_roundmode,
    input  logic [15:0]      fma_result,
    input  logic [3:0]       fma_flags,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [15:0]      resp_result,
    output logic [3:0]       resp_flags,
    output logic [TAG_W-1:0] resp_tag,
    output logic [3:0]       fflags,
    input  logic             fflags_clr,
    output logic             busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0]  CNT_LOAD    = 4'(EXEC_CYCLES - 1);
    localparam logic [2:0]  OP_ILLEGAL  = 3'd7;
    localparam logic [15:0] CANON_NAN   = 16'h7E00;
    localparam logic [3:0]  FLAG_NV     = 4'b1000;

    // Controls are packed as {mul, add, negr, negz}.
    function automatic logic [3:0] decode_op(input logic [2:0] op);
        logic [3:0] ctrl;
        case (op)
            3'd0:    ctrl = 4'b0100;
            3'd1:    ctrl = 4'b0101;
            3'd2:    ctrl = 4'b1000;
            3'd3:    ctrl = 4'b1100;
            3'd4:    ctrl = 4'b1101;
            3'd5:    ctrl = 4'b1110;
            3'd6:    ctrl = 4'b1111;
            default: ctrl = 4'b0000;
        endcase
        return ctrl;
    endfunction

    state_t             r_state;
    state_t             w_next_state;
    logic [3:0]         r_cnt;
    logic [15:0]        r_fma_x;
    logic [15:0]        r_fma_y;
    logic [15:0]        r_fma_z;
    logic [3:0]         r_ctrl;
    logic [1:0]         r_rm;
    logic [TAG_W-1:0]   r_tag;
    logic [15:0]        r_resp_result;
    logic [3:0]         r_resp_flags;
    logic [TAG_W-1:0]   r_resp_tag;
    logic [3:0]         r_fflags;
    logic               w_req_ready;
    logic               w_accept;
    logic               w_illegal;
    logic               w_retire;
    logic               w_exec_done;

    // In RESP, acceptance is gated by the consumer so retire and issue share an edge.
    always_comb begin
        w_req_ready = 1'b0;
        case (r_state)
            S_IDLE:  w_req_ready = 1'b1;
            S_RESP:  w_req_ready = resp_ready;
            default: w_req_ready = 1'b0;
        endcase
    end

    assign w_accept    = req_valid & w_req_ready;
    assign w_illegal   = (req_op == OP_ILLEGAL);
    assign w_retire    = (r_state == S_RESP) & resp_ready;
    assign w_exec_done = (r_state == S_EXEC) && (r_cnt == 4'd0);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_illegal ? S_RESP : S_EXEC;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_EXEC: begin
                if (w_exec_done) begin
                    w_next_state = S_RESP;
                end else begin
                    w_next_state = S_EXEC;
                end
            end
            S_RESP: begin
                if (w_accept) begin
                    w_next_state = w_illegal ? S_RESP : S_EXEC;
                end else if (w_retire) begin
                    w_next_state = S_IDLE;
                end else begin
                    w_next_state = S_RESP;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Operands and controls move only when a legal op is accepted.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_fma_x <= 16'd0;
            r_fma_y <= 16'd0;
            r_fma_z <= 16'd0;
            r_ctrl  <= 4'd0;
            r_rm    <= 2'd0;
            r_tag   <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept && !w_illegal) begin
                r_fma_x <= req_x;
                r_fma_y <= req_y;
                r_fma_z <= req_z;
                r_ctrl  <= decode_op(req_op);
                r_rm    <= req_rm;
                r_tag   <= req_tag;
                r_cnt   <= CNT_LOAD;
            end else if ((r_state == S_EXEC) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end else begin
                r_cnt <= r_cnt;
            end
        end
    end

    // Response capture: illegal ops answer immediately, legal ops at the end of EXEC.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_resp_result <= 16'd0;
            r_resp_flags  <= 4'd0;
            r_resp_tag    <= '0;
        end else if (w_accept && w_illegal) begin
            r_resp_result <= CANON_NAN;
            r_resp_flags  <= FLAG_NV;
            r_resp_tag    <= req_tag;
        end else if (w_exec_done) begin
            r_resp_result <= fma_result;
            r_resp_flags  <= fma_flags;
            r_resp_tag    <= r_tag;
        end else begin
            r_resp_result <= r_resp_result;
            r_resp_flags  <= r_resp_flags;
            r_resp_tag    <= r_resp_tag;
        end
    end

    // A clear coinciding with a retire keeps only the retiring flags.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_fflags <= 4'd0;
        end else if (w_retire) begin
            r_fflags <= (fflags_clr ? 4'd0 : r_fflags) | r_resp_flags;
        end else if (fflags_clr) begin
            r_fflags <= 4'd0;
        end else begin
            r_fflags <= r_fflags;
        end
    end

    assign req_ready     = w_req_ready;
    assign fma_x         = r_fma_x;
    assign fma_y         = r_fma_y;
    assign fma_z         = r_fma_z;
    assign fma_mul       = r_ctrl[3];
    assign fma_add       = r_ctrl[2];
    assign fma_negr      = r_ctrl[1];
    assign fma_negz      = r_ctrl[0];
    assign fma_roundmode = r_rm;
    assign resp_valid    = (r_state == S_RESP);
    assign resp_result   = r_resp_result;
    assign resp_flags    = r_resp_flags;
    assign resp_tag      = r_resp_tag;
    assign fflags        = r_fflags;
    assign busy          = (r_state != S_IDLE);

endmodule
